lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Parameters
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command/data FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter POWER_ON_CYC, default 750000, cycles waited after reset before the first transfer.
REQ-003 SHALL have parameter SETUP_CYC, default 4, cycles RS/DATA are stable before EN rises.
REQ-004 SHALL have parameter PULSE_CYC, default 25, cycles EN is held high.
REQ-005 SHALL have parameter HOLD_CYC, default 4, cycles RS/DATA are held after EN falls.
REQ-006 SHALL have parameter WAIT_CYC, default 2500, execution wait after a normal transfer.
REQ-007 SHALL have parameter CLEAR_WAIT_CYC, default 82000, execution wait after a clear/home command (RS=0, DATA 0x01 or 0x02).

Interface
REQ-008 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port i_wr_valid, input, 1, requester offers one LCD byte.
REQ-011 SHALL have port i_wr_rs, input, 1, register select of the offered byte (0 command, 1 data).
REQ-012 SHALL have port i_wr_data, input, 8, the offered byte.
REQ-013 SHALL have port i_lcd_on, input, 1, LCD power/backlight enable.
REQ-014 SHALL have port o_wr_ready, output, 1, FIFO can accept a byte this cycle.
REQ-015 SHALL have port o_busy, output, 1, FIFO non-empty or FSM not in IDLE.
REQ-016 SHALL have port o_io_lcd, output, 32, LCD pins: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA, all other bits 0.

Function
REQ-017 SHALL accept a byte on a rising edge where i_wr_valid=1 and o_wr_ready=1; o_wr_ready = FIFO not full, combinational from the count.
REQ-018 SHALL ignore i_wr_valid while full; the offered byte is dropped and the FIFO is unchanged.
REQ-019 SHALL pop FIFO entries in push order, only on the edge on which the FSM leaves IDLE.
REQ-020 SHALL not pop a byte on the same edge on which it is pushed; a push into an empty FIFO becomes visible one cycle later.
REQ-021 SHALL allow a simultaneous push and pop when not full; the count is unchanged.
REQ-022 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-023 SHALL implement an FSM with states INIT_WAIT, IDLE, SETUP, PULSE, HOLD, EXEC_WAIT, all timed by one shared down-counter.
REQ-024 SHALL stay in INIT_WAIT for POWER_ON_CYC cycles after reset, then go to IDLE; pushes are accepted during INIT_WAIT.
REQ-025 SHALL go from IDLE to SETUP when the FIFO is non-empty, registering the popped RS/DATA into o_io_lcd[9] and [7:0] on that edge.
REQ-026 SHALL go from SETUP to PULSE after SETUP_CYC cycles, from PULSE to HOLD after PULSE_CYC cycles, and from HOLD to EXEC_WAIT after HOLD_CYC cycles.
REQ-027 SHALL drive EN=1 exactly in PULSE, i.e. for PULSE_CYC cycles, and EN=0 in every other state.
REQ-028 SHALL keep RS/DATA constant from SETUP entry through HOLD exit, and keep their last values in EXEC_WAIT and IDLE.
REQ-029 SHALL wait CLEAR_WAIT_CYC cycles in EXEC_WAIT if the transfer was RS=0 with DATA 0x01/0x02, otherwise WAIT_CYC, then go to IDLE.
REQ-030 SHALL register o_io_lcd[31] from i_lcd_on every cycle (1-cycle latency) and drive RW=0 constantly.
REQ-031 SHALL derive o_busy from registered state and count, with no combinational path from the inputs.

Reset
REQ-032 SHALL, on any edge with i_rst=1, including mid-transfer, set the state to INIT_WAIT, load the counter with POWER_ON_CYC, flush the FIFO (count 0, pointers 0), and set o_io_lcd=0 (EN low immediately).
REQ-033 SHALL give priority to reset over any simultaneous push; o_wr_ready=1 and o_busy=1 after reset.

Verification (FIFO_DEPTH=4, POWER_ON_CYC=10, SETUP_CYC=2, PULSE_CYC=4, HOLD_CYC=2, WAIT_CYC=8, CLEAR_WAIT_CYC=20)
REQ-034 SHALL pass: reset released, no pushes -> o_io_lcd=0, o_busy=1 for 10 cycles, then o_busy=0.
REQ-035 SHALL pass: in IDLE, push RS=1 DATA=0x41 -> RS/DATA appear 2 edges later, EN high for exactly 4 cycles starting 2 cycles after that, o_busy falls 2+4+2+8 cycles after SETUP entry.
REQ-036 SHALL pass: push RS=0 DATA=0x01 -> execution wait is 20 cycles, not 8.
REQ-037 SHALL pass: 5 pushes during INIT_WAIT -> 4 accepted, 5th dropped with o_wr_ready=0; the 4 EN pulses occur in push order.
REQ-038 SHALL pass: reset asserted while in PULSE -> EN=0 on the next edge, FIFO empty, INIT_WAIT restarts.
REQ-039 SHALL pass: toggle i_lcd_on mid-transfer -> o_io_lcd[31] follows 1 cycle later; timing and EN are unaffected.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller.
// Bytes offered on the write port are queued in a small FIFO and replayed to
// the LCD pins as setup / enable-pulse / hold / execution-wait sequences, all
// timed by one shared down-counter. A power-on wait follows every reset.
module lcd_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned POWER_ON_CYC   = 750000,
    parameter int unsigned SETUP_CYC      = 4,
    parameter int unsigned PULSE_CYC      = 25,
    parameter int unsigned HOLD_CYC       = 4,
    parameter int unsigned WAIT_CYC       = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_valid,
    input  logic        i_wr_rs,
    input  logic [7:0]  i_wr_data,
    input  logic        i_lcd_on,
    output logic        o_wr_ready,
    output logic        o_busy,
    output logic [31:0] o_io_lcd
);

    // FIFO geometry: pointers wrap naturally because the depth is a power of two
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // The shared timer must hold the longest interval loaded into it
    localparam int unsigned MAX_AB  = (POWER_ON_CYC > CLEAR_WAIT_CYC) ? POWER_ON_CYC : CLEAR_WAIT_CYC;
    localparam int unsigned MAX_CD  = (WAIT_CYC > PULSE_CYC) ? WAIT_CYC : PULSE_CYC;
    localparam int unsigned MAX_EF  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MAX_CYC = (MAX_ABC > MAX_EF) ? MAX_ABC : MAX_EF;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        INIT_WAIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC_WAIT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TMR_W-1:0]   tmr;
    logic [TMR_W-1:0]   tmr_next;
    logic               tmr_last;

    logic [8:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic [8:0]         fifo_head;
    logic               push;
    logic               pop;
    logic               fifo_empty;

    logic               lcd_on;
    logic               lcd_en;
    logic               lcd_rs;
    logic [7:0]         lcd_data;
    logic               is_clear;

    assign fifo_empty = (fifo_count == '0);
    assign o_wr_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push       = i_wr_valid && o_wr_ready;
    // Popping is tied to the IDLE->SETUP transition, which only looks at the
    // registered count, so a byte is never popped on the edge it is pushed.
    assign pop        = (state == IDLE) && (state_next == SETUP);
    assign fifo_head  = fifo_mem[rd_ptr];

    // Clear display (0x01) and return home (0x02) need the long execution wait
    assign is_clear = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02));

    assign tmr_last = (tmr <= TMR_W'(1));

    // FIFO storage: written on every accepted push, never reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            fifo_mem[wr_ptr] <= {i_wr_rs, i_wr_data};
        end
    end

    // FIFO pointers and occupancy count; reset flushes the queue
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FSM state and shared timer registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= INIT_WAIT;
            tmr   <= TMR_W'(POWER_ON_CYC);
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
        end
    end

    // Next-state and timer reload: each timed state lasts exactly its loaded count
    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        case (state)
            INIT_WAIT: begin
                if (tmr_last) begin
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SETUP;
                    tmr_next   = TMR_W'(SETUP_CYC);
                end
            end
            SETUP: begin
                if (tmr_last) begin
                    state_next = PULSE;
                    tmr_next   = TMR_W'(PULSE_CYC);
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            PULSE: begin
                if (tmr_last) begin
                    state_next = HOLD;
                    tmr_next   = TMR_W'(HOLD_CYC);
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            HOLD: begin
                if (tmr_last) begin
                    state_next = EXEC_WAIT;
                    tmr_next   = is_clear ? TMR_W'(CLEAR_WAIT_CYC) : TMR_W'(WAIT_CYC);
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            EXEC_WAIT: begin
                if (tmr_last) begin
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            default: begin
                state_next = INIT_WAIT;
                tmr_next   = TMR_W'(POWER_ON_CYC);
            end
        endcase
    end

    // LCD pin registers: EN tracks the PULSE state, RS/DATA latch on pop
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lcd_on   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            lcd_on <= i_lcd_on;
            lcd_en <= (state_next == PULSE);
            if (pop) begin
                lcd_rs   <= fifo_head[8];
                lcd_data <= fifo_head[7:0];
            end
        end
    end

    assign o_busy   = (state != IDLE) || !fifo_empty;
    assign o_io_lcd = {lcd_on, 20'd0, lcd_en, lcd_rs, 1'b0, lcd_data};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed testbench for lcd_ctrl with shortened timing parameters.
module tb_lcd_ctrl;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_wr_valid = 1'b0;
    logic        i_wr_rs = 1'b0;
    logic [7:0]  i_wr_data = '0;
    logic        i_lcd_on = 1'b0;
    logic        o_wr_ready;
    logic        o_busy;
    logic [31:0] o_io_lcd;

    int n_cmp = 0;
    int n_bad = 0;

    lcd_ctrl #(
        .FIFO_DEPTH     (4),
        .POWER_ON_CYC   (10),
        .SETUP_CYC      (2),
        .PULSE_CYC      (4),
        .HOLD_CYC       (2),
        .WAIT_CYC       (8),
        .CLEAR_WAIT_CYC (20)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_wr_valid (i_wr_valid),
        .i_wr_rs    (i_wr_rs),
        .i_wr_data  (i_wr_data),
        .i_lcd_on   (i_lcd_on),
        .o_wr_ready (o_wr_ready),
        .o_busy     (o_busy),
        .o_io_lcd   (o_io_lcd)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Observe a transfer starting from the sample right after SETUP entry.
    // Returns when o_busy falls (or after 200 edges); counts are edge numbers.
    task automatic run_transfer(input bit toggle_on, output int rise_at, output int en_cycles,
                                output int done_at, output bit stable, output bit on_ok);
        logic [8:0] held;
        logic       v;
        held      = {o_io_lcd[9], o_io_lcd[7:0]};
        rise_at   = -1;
        en_cycles = 0;
        done_at   = -1;
        stable    = 1'b1;
        on_ok     = 1'b1;
        for (int n = 1; n <= 200 && done_at < 0; n++) begin
            if (toggle_on && (n % 3 == 0)) begin
                i_lcd_on = ~i_lcd_on;
                #1;
                if (o_io_lcd[31] === i_lcd_on) on_ok = 1'b0;
            end
            v = i_lcd_on;
            tick();
            if (o_io_lcd[31] !== v) on_ok = 1'b0;
            if (o_io_lcd[10] === 1'b1) begin
                en_cycles++;
                if (rise_at < 0) rise_at = n;
            end
            if ({o_io_lcd[9], o_io_lcd[7:0]} !== held) stable = 1'b0;
            if (o_busy === 1'b0) done_at = n;
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_wr_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        n_cmp++;
        if (o_io_lcd !== 32'h0) begin
            n_bad++; $display("FAIL reset_io: got %h expected %h", o_io_lcd, 32'h0);
        end
        n_cmp++;
        if (o_wr_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %b expected 1", o_wr_ready);
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (o_busy !== 1'b1) begin
                n_bad++; $display("FAIL reset_busy_hold[%0d]: got %b expected 1", i, o_busy);
            end
            tick();
        end
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy_release: got %b expected 0", o_busy);
        end
        n_cmp++;
        if (o_io_lcd !== 32'h0) begin
            n_bad++; $display("FAIL reset_io_idle: got %h expected %h", o_io_lcd, 32'h0);
        end
    endtask

    task automatic test_data_write;
        int rise_at, en_cycles, done_at;
        bit stable, on_ok;
        i_wr_valid = 1'b1; i_wr_rs = 1'b1; i_wr_data = 8'h41;
        tick();
        i_wr_valid = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_bad++; $display("FAIL data_busy_after_push: got %b expected 1", o_busy);
        end
        n_cmp++;
        if (o_io_lcd[9:0] !== 10'h000) begin
            n_bad++; $display("FAIL data_not_yet: got %h expected %h", o_io_lcd[9:0], 10'h000);
        end
        tick();
        n_cmp++;
        if ({o_io_lcd[10:9], o_io_lcd[7:0]} !== 10'h141) begin
            n_bad++; $display("FAIL data_setup_entry: got %h expected %h",
                              {o_io_lcd[10:9], o_io_lcd[7:0]}, 10'h141);
        end
        run_transfer(1'b0, rise_at, en_cycles, done_at, stable, on_ok);
        n_cmp++;
        if (rise_at !== 2) begin
            n_bad++; $display("FAIL data_en_rise: got %0d expected 2", rise_at);
        end
        n_cmp++;
        if (en_cycles !== 4) begin
            n_bad++; $display("FAIL data_en_width: got %0d expected 4", en_cycles);
        end
        n_cmp++;
        if (done_at !== 16) begin
            n_bad++; $display("FAIL data_busy_fall: got %0d expected 16", done_at);
        end
        n_cmp++;
        if (stable !== 1'b1) begin
            n_bad++; $display("FAIL data_rs_data_stable: got %b expected 1", stable);
        end
    endtask

    task automatic test_clear;
        logic [8:0] vec [4];
        int         exp_done [4];
        int rise_at, en_cycles, done_at;
        bit stable, on_ok;
        vec[0] = 9'h001; exp_done[0] = 28;
        vec[1] = 9'h002; exp_done[1] = 28;
        vec[2] = 9'h102; exp_done[2] = 16;
        vec[3] = 9'h003; exp_done[3] = 16;
        for (int k = 0; k < 4; k++) begin
            i_wr_valid = 1'b1; i_wr_rs = vec[k][8]; i_wr_data = vec[k][7:0];
            tick();
            i_wr_valid = 1'b0;
            tick();
            n_cmp++;
            if ({o_io_lcd[9], o_io_lcd[7:0]} !== vec[k]) begin
                n_bad++; $display("FAIL clear_latch[%0d]: got %h expected %h",
                                  k, {o_io_lcd[9], o_io_lcd[7:0]}, vec[k]);
            end
            run_transfer(1'b0, rise_at, en_cycles, done_at, stable, on_ok);
            n_cmp++;
            if (done_at !== exp_done[k]) begin
                n_bad++; $display("FAIL clear_exec_wait[%0d]: got %0d expected %0d",
                                  k, done_at, exp_done[k]);
            end
            n_cmp++;
            if (en_cycles !== 4) begin
                n_bad++; $display("FAIL clear_en_width[%0d]: got %0d expected 4", k, en_cycles);
            end
        end
    endtask

    task automatic test_fifo_full;
        logic [8:0] exp_b [4];
        logic [8:0] got [8];
        int  p;
        bit  prev_en;
        bit  done;
        exp_b[0] = 9'h110; exp_b[1] = 9'h020; exp_b[2] = 9'h130; exp_b[3] = 9'h003;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (o_wr_ready !== 1'b1) begin
                n_bad++; $display("FAIL full_ready_before[%0d]: got %b expected 1", k, o_wr_ready);
            end
            i_wr_valid = 1'b1; i_wr_rs = exp_b[k][8]; i_wr_data = exp_b[k][7:0];
            tick();
        end
        n_cmp++;
        if (o_wr_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_ready_low: got %b expected 0", o_wr_ready);
        end
        i_wr_rs = 1'b1; i_wr_data = 8'h55;
        tick();
        i_wr_valid = 1'b0;
        n_cmp++;
        if (o_wr_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_ready_after_drop: got %b expected 0", o_wr_ready);
        end
        p = 0;
        prev_en = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            tick();
            if (o_io_lcd[10] === 1'b1 && !prev_en) begin
                if (p < 8) got[p] = {o_io_lcd[9], o_io_lcd[7:0]};
                p++;
            end
            prev_en = (o_io_lcd[10] === 1'b1);
            if (o_busy === 1'b0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++; $display("FAIL full_drain_timeout: got busy %b expected 0", o_busy);
        end
        n_cmp++;
        if (p !== 4) begin
            n_bad++; $display("FAIL full_pulse_count: got %0d expected 4", p);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= p || got[k] !== exp_b[k]) begin
                n_bad++; $display("FAIL full_order[%0d]: got %h expected %h",
                                  k, (k < p) ? got[k] : 9'h0, exp_b[k]);
            end
        end
    endtask

    task automatic test_reset_mid_pulse;
        bit en_seen;
        bit quiet;
        i_wr_valid = 1'b1; i_wr_rs = 1'b1; i_wr_data = 8'h61;
        tick();
        i_wr_data = 8'h62;
        tick();
        i_wr_valid = 1'b0;
        for (int k = 0; k < 20 && o_io_lcd[10] !== 1'b1; k++) tick();
        en_seen = (o_io_lcd[10] === 1'b1);
        n_cmp++;
        if (!en_seen) begin
            n_bad++; $display("FAIL midreset_en_wait: got %b expected 1", o_io_lcd[10]);
        end
        tick();
        i_rst = 1'b1;
        i_wr_valid = 1'b1; i_wr_rs = 1'b1; i_wr_data = 8'h63;
        tick();
        i_rst = 1'b0;
        i_wr_valid = 1'b0;
        n_cmp++;
        if (o_io_lcd !== 32'h0) begin
            n_bad++; $display("FAIL midreset_io: got %h expected %h", o_io_lcd, 32'h0);
        end
        n_cmp++;
        if (o_wr_ready !== 1'b1 || o_busy !== 1'b1) begin
            n_bad++; $display("FAIL midreset_flags: got ready %b busy %b expected ready 1 busy 1",
                              o_wr_ready, o_busy);
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (o_busy !== 1'b1) begin
                n_bad++; $display("FAIL midreset_init_wait[%0d]: got %b expected 1", i, o_busy);
            end
            tick();
        end
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (o_busy !== 1'b0 || o_io_lcd[10] !== 1'b0) quiet = 1'b0;
            tick();
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++; $display("FAIL midreset_fifo_flushed: got %b expected 1", quiet);
        end
    endtask

    task automatic test_lcd_on;
        int rise_at, en_cycles, done_at;
        bit stable, on_ok;
        i_lcd_on = 1'b1;
        #1;
        n_cmp++;
        if (o_io_lcd[31] !== 1'b0) begin
            n_bad++; $display("FAIL lcd_on_latency: got %b expected 0", o_io_lcd[31]);
        end
        tick();
        n_cmp++;
        if (o_io_lcd[31] !== 1'b1) begin
            n_bad++; $display("FAIL lcd_on_follow: got %b expected 1", o_io_lcd[31]);
        end
        i_wr_valid = 1'b1; i_wr_rs = 1'b1; i_wr_data = 8'h42;
        tick();
        i_wr_valid = 1'b0;
        tick();
        n_cmp++;
        if ({o_io_lcd[31], o_io_lcd[9], o_io_lcd[7:0]} !== 10'h342) begin
            n_bad++; $display("FAIL lcd_on_setup: got %h expected %h",
                              {o_io_lcd[31], o_io_lcd[9], o_io_lcd[7:0]}, 10'h342);
        end
        run_transfer(1'b1, rise_at, en_cycles, done_at, stable, on_ok);
        n_cmp++;
        if (on_ok !== 1'b1) begin
            n_bad++; $display("FAIL lcd_on_toggle: got %b expected 1", on_ok);
        end
        n_cmp++;
        if (rise_at !== 2 || en_cycles !== 4 || done_at !== 16) begin
            n_bad++; $display("FAIL lcd_on_timing: got rise %0d en %0d done %0d expected 2 4 16",
                              rise_at, en_cycles, done_at);
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_clear();
        test_fifo_full();
        test_reset_mid_pulse();
        test_lcd_on();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
